// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: lamp encodings,
// phase codes and the phase-timer width.
package traffic_pkg;

    localparam int unsigned TIMER_W = 8;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    typedef enum logic [2:0] {
        ALLRED_A    = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALLRED_B    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5
    } phase_e;

    // Timer value on which an N-tick phase ends; a zero-length phase
    // behaves as a one-tick phase.
    function automatic logic [TIMER_W-1:0] end_count(input logic [TIMER_W-1:0] ticks);
        return (ticks == '0) ? '0 : ticks - 8'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV fast_clk
// cycles. tick is decoded from the registered count, so the first tick is
// sampled on the TICK_DIV-th rising edge after reset release.
module tick_prescaler #(
    parameter logic [24:0] TICK_DIV = 25'd25_000_000
) (
    input  logic fast_clk,
    input  logic reset,
    output logic tick
);

    logic [24:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TICK_DIV - 25'd1);

    // Wrap to zero on the tick cycle, otherwise count up.
    always_comb begin
        cnt_d = cnt_q + 25'd1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer. Main road rests in GREEN; a latched
// side-road request hands the right of way to the side road through
// YELLOW and an all-red clearance, then back again.
// Optional pedestrian support is compiled in with TRAFFIC_PED_EN
// (adds ped_req input and walk output).
//
// state       | meaning
// ALLRED_A    | clearance before main GREEN (also reset / recovery state)
// MAIN_GREEN  | main road green, waits for min time plus a request
// MAIN_YELLOW | main road yellow
// ALLRED_B    | clearance before side GREEN
// SIDE_GREEN  | side road green, fixed length
// SIDE_YELLOW | side road yellow
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter logic [24:0] TICK_DIV         = 25'd25_000_000,
    parameter logic [7:0]  ALLRED_TICKS     = 8'd2,
    parameter logic [7:0]  MAIN_MIN_TICKS   = 8'd10,
    parameter logic [7:0]  YELLOW_TICKS     = 8'd3,
    parameter logic [7:0]  SIDE_GREEN_TICKS = 8'd6
) (
    input  logic       fast_clk,
    input  logic       reset,
    input  logic       side_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase,
    output logic       tick
`ifdef TRAFFIC_PED_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    localparam logic [TIMER_W-1:0] ALLRED_END   = end_count(ALLRED_TICKS);
    localparam logic [TIMER_W-1:0] MAIN_MIN_END = end_count(MAIN_MIN_TICKS);
    localparam logic [TIMER_W-1:0] YELLOW_END   = end_count(YELLOW_TICKS);
    localparam logic [TIMER_W-1:0] SIDE_END     = end_count(SIDE_GREEN_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;

    phase_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q, req_d;
    logic [2:0]         main_q, main_d;
    logic [2:0]         side_q, side_d;
    logic               enter_side;
    logic               svc_req;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .fast_clk(fast_clk),
        .reset   (reset),
        .tick    (tick)
    );

`ifdef TRAFFIC_PED_EN
    logic ped_q, ped_d;
    logic walk_q, walk_d;
    assign svc_req = req_q | ped_q;
    assign walk    = walk_q;
`else
    assign svc_req = req_q;
`endif

    assign main_light = main_q;
    assign side_light = side_q;
    assign phase      = state_q;

    // Next state, phase timer, request latch and next lamp values.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        main_d  = RED;
        side_d  = RED;

        case (state_q)
            ALLRED_A:    if (tick && timer_q == ALLRED_END) state_d = MAIN_GREEN;
            MAIN_GREEN:  if (tick && timer_q >= MAIN_MIN_END && svc_req) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (tick && timer_q == YELLOW_END) state_d = ALLRED_B;
            ALLRED_B:    if (tick && timer_q == ALLRED_END) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (tick && timer_q == SIDE_END)   state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (tick && timer_q == YELLOW_END) state_d = ALLRED_A;
            default:     state_d = ALLRED_A;
        endcase

        enter_side = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

        // The clear on side-green entry overrides a request in the same cycle.
        req_d = enter_side ? 1'b0 : (req_q | side_req);

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && timer_q != TIMER_MAX) begin
            timer_d = timer_q + 8'd1;
        end

        case (state_d)
            MAIN_GREEN:  main_d = GREEN;
            MAIN_YELLOW: main_d = YELLOW;
            SIDE_GREEN:  side_d = GREEN;
            SIDE_YELLOW: side_d = YELLOW;
            default: begin
                main_d = RED;
                side_d = RED;
            end
        endcase
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian latch; walk is decided once at side-green entry and held.
    always_comb begin
        ped_d  = enter_side ? 1'b0 : (ped_q | ped_req);
        walk_d = 1'b0;
        if (state_d == SIDE_GREEN) begin
            walk_d = enter_side ? ped_q : walk_q;
        end
    end

    // Pedestrian registers.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            ped_q  <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            ped_q  <= ped_d;
            walk_q <= walk_d;
        end
    end
`endif

    // State, timer, request latch and lamp registers.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_q <= ALLRED_A;
            timer_q <= '0;
            req_q   <= 1'b0;
            main_q  <= RED;
            side_q  <= RED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            main_q  <= main_d;
            side_q  <= side_d;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: table of directed vectors for the
// main instance plus hand sequences for async reset, zero-length phases
// and (with TRAFFIC_PED_EN) the pedestrian walk signal.
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic       fast_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       side_req = 1'b0;
    logic [2:0] main_light, side_light, phase;
    logic       tick;

    logic       side_req0 = 1'b0;
    logic [2:0] main_light0, side_light0, phase0;
    logic       tick0;

`ifdef TRAFFIC_PED_EN
    logic ped_req  = 1'b0;
    logic walk;
    logic ped_req0 = 1'b0;
    logic walk0;
`endif

    int edge_n = 0;
    int n_vec  = 0;
    int n_err  = 0;

    traffic_intersection_ctrl #(
        .TICK_DIV        (25'd4),
        .ALLRED_TICKS    (8'd2),
        .MAIN_MIN_TICKS  (8'd5),
        .YELLOW_TICKS    (8'd3),
        .SIDE_GREEN_TICKS(8'd4)
    ) u_dut (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .side_req  (side_req),
        .main_light(main_light),
        .side_light(side_light),
        .phase     (phase),
        .tick      (tick)
`ifdef TRAFFIC_PED_EN
        ,
        .ped_req   (ped_req),
        .walk      (walk)
`endif
    );

    // Smallest legal divider and zero durations (each treated as one tick).
    traffic_intersection_ctrl #(
        .TICK_DIV        (25'd2),
        .ALLRED_TICKS    (8'd0),
        .MAIN_MIN_TICKS  (8'd0),
        .YELLOW_TICKS    (8'd0),
        .SIDE_GREEN_TICKS(8'd0)
    ) u_dut0 (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .side_req  (side_req0),
        .main_light(main_light0),
        .side_light(side_light0),
        .phase     (phase0),
        .tick      (tick0)
`ifdef TRAFFIC_PED_EN
        ,
        .ped_req   (ped_req0),
        .walk      (walk0)
`endif
    );

    always #5 fast_clk = ~fast_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rst;
        int         n;
        logic       req;
        logic [2:0] m;
        logic [2:0] s;
        logic [2:0] p;
        logic       t;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit rst, input int n, input logic req,
                                input logic [2:0] m, input logic [2:0] s,
                                input logic [2:0] p, input logic t);
        vec_t v;
        v.rst = rst; v.n = n; v.req = req; v.m = m; v.s = s; v.p = p; v.t = t;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h, expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        edge_n++;
        #1;
        if (main_light != R && side_light != R) begin
            n_err++;
            $display("FAIL overlap @edge %0d: main %b side %b both non-red", edge_n, main_light, side_light);
        end
        if (main_light0 != R && side_light0 != R) begin
            n_err++;
            $display("FAIL overlap0 @edge %0d: main %b side %b both non-red", edge_n, main_light0, side_light0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #7;
        @(negedge fast_clk);
        reset  = 1'b0;
        edge_n = 0;
        #1;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    initial begin
        // Scenario: no request, main holds green
        add(1,   0, 0, R, R, 3'd0, 0);
        add(0,   8, 0, G, R, 3'd1, 0);
        add(0, 208, 0, G, R, 3'd1, 0);
        // Scenario: one-cycle request sampled on edge 12
        add(1,   0, 0, R, R, 3'd0, 0);
        add(0,   3, 0, R, R, 3'd0, 1);
        add(0,   4, 0, R, R, 3'd0, 0);
        add(0,   7, 0, R, R, 3'd0, 1);
        add(0,   8, 0, G, R, 3'd1, 0);
        add(0,  11, 0, G, R, 3'd1, 1);
        add(0,  12, 1, G, R, 3'd1, 0);
        add(0,  27, 0, G, R, 3'd1, 1);
        add(0,  28, 0, Y, R, 3'd2, 0);
        add(0,  39, 0, Y, R, 3'd2, 1);
        add(0,  40, 0, R, R, 3'd3, 0);
        add(0,  47, 0, R, R, 3'd3, 1);
        add(0,  48, 0, R, G, 3'd4, 0);
        add(0,  63, 0, R, G, 3'd4, 1);
        add(0,  64, 0, R, Y, 3'd5, 0);
        add(0,  75, 0, R, Y, 3'd5, 1);
        add(0,  76, 0, R, R, 3'd0, 0);
        add(0,  84, 0, G, R, 3'd1, 0);
        add(0, 200, 0, G, R, 3'd1, 0);
        add(0, 283, 0, G, R, 3'd1, 1);
        // Scenario: request held high, 76-cycle round
        add(1,   0, 1, R, R, 3'd0, 0);
        add(0,   8, 1, G, R, 3'd1, 0);
        add(0,  27, 1, G, R, 3'd1, 1);
        add(0,  28, 1, Y, R, 3'd2, 0);
        add(0,  48, 1, R, G, 3'd4, 0);
        add(0,  76, 1, R, R, 3'd0, 0);
        add(0,  84, 1, G, R, 3'd1, 0);
        add(0, 103, 1, G, R, 3'd1, 1);
        add(0, 104, 1, Y, R, 3'd2, 0);
        add(0, 160, 1, G, R, 3'd1, 0);
        add(0, 179, 1, G, R, 3'd1, 1);
        add(0, 180, 1, Y, R, 3'd2, 0);
        // Scenario: request only on the side-green entry edge is dropped
        add(1,   0, 0, R, R, 3'd0, 0);
        add(0,  11, 0, G, R, 3'd1, 1);
        add(0,  12, 1, G, R, 3'd1, 0);
        add(0,  47, 0, R, R, 3'd3, 1);
        add(0,  48, 1, R, G, 3'd4, 0);
        add(0,  84, 0, G, R, 3'd1, 0);
        add(0, 300, 0, G, R, 3'd1, 0);

        foreach (vq[i]) begin
            side_req = vq[i].req;
            if (vq[i].rst) do_reset();
            step_to(vq[i].n);
            check($sformatf("vec%0d {main,side,phase,tick}", i),
                  {22'd0, main_light, side_light, phase, tick},
                  {22'd0, vq[i].m, vq[i].s, vq[i].p, vq[i].t});
        end

        // Async reset mid side-yellow, between clock edges
        side_req = 1'b0;
        do_reset();
        step_to(11);
        side_req = 1'b1;
        step();
        side_req = 1'b0;
        step_to(67);
        check("pre-reset side yellow", {22'd0, main_light, side_light, phase, tick},
              {22'd0, R, Y, 3'd5, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        check("async reset immediate", {22'd0, main_light, side_light, phase, tick},
              {22'd0, R, R, 3'd0, 1'b0});
        @(negedge fast_clk);
        reset  = 1'b0;
        edge_n = 0;
        #1;
        step_to(3);
        check("restart tick edge 4", {31'd0, tick}, {31'd0, 1'b1});
        step_to(7);
        check("restart allred", {29'd0, phase}, {29'd0, 3'd0});
        step_to(8);
        check("restart main green", {26'd0, main_light, side_light}, {26'd0, G, R});

        // Zero-length phases with TICK_DIV=2 on the second instance
        do_reset();
        side_req0 = 1'b1;
        step_to(2);
        check("zero: main green", {29'd0, phase0}, {29'd0, 3'd1});
        step_to(3);
        side_req0 = 1'b0;
        step_to(4);
        check("zero: main yellow", {26'd0, main_light0, phase0}, {26'd0, Y, 3'd2});
        step_to(6);
        check("zero: allred b", {29'd0, phase0}, {29'd0, 3'd3});
        step_to(8);
        check("zero: side green", {26'd0, side_light0, phase0}, {26'd0, G, 3'd4});
        step_to(10);
        check("zero: side yellow", {29'd0, phase0}, {29'd0, 3'd5});
        step_to(12);
        check("zero: allred a", {29'd0, phase0}, {29'd0, 3'd0});
        step_to(14);
        check("zero: main green again", {29'd0, phase0}, {29'd0, 3'd1});
        step_to(40);
        check("zero: main green holds", {29'd0, phase0}, {29'd0, 3'd1});

`ifdef TRAFFIC_PED_EN
        // Pedestrian pulse alone triggers a side cycle with walk in side green
        side_req = 1'b0;
        do_reset();
        check("ped: walk reset", {31'd0, walk}, {31'd0, 1'b0});
        step_to(11);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step_to(28);
        check("ped: main yellow", {29'd0, phase}, {29'd0, 3'd2});
        step_to(47);
        check("ped: walk before side green", {31'd0, walk}, {31'd0, 1'b0});
        step_to(48);
        check("ped: walk at side green", {28'd0, phase, walk}, {28'd0, 3'd4, 1'b1});
        step_to(63);
        check("ped: walk end of side green", {31'd0, walk}, {31'd0, 1'b1});
        step_to(64);
        check("ped: walk off in side yellow", {28'd0, phase, walk}, {28'd0, 3'd5, 1'b0});
        step_to(200);
        check("ped: latch cleared, main holds", {28'd0, phase, walk}, {28'd0, 3'd1, 1'b0});
        check("ped: unused instance walk", {31'd0, walk0}, {31'd0, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
